multi_dest_rr_arb: RTL and testbench
====================================

Name: multi_dest_rr_arb

Overview:
- Shares one multi-destination broadcast path among SRC_N requesters.
- Each request carries a DST_N-bit destination mask.
- The arbiter grants one source at a time, round-robin, and drives per-destination valids.
- It tracks which destinations have already accepted, and pops the source only once every masked destination has taken the beat.
- Sits in front of the team's 2-destination backward pipe stage; its master side connects directly to that stage's valid/data/ready inputs.

Parameters:
- DATA_W, 256, payload width.
- SRC_N, 4, number of requesters; range 2..16.
- DST_N, 2, number of destinations; width of the dest mask and of the valid/ready vectors.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid_in  in  SRC_N  per-source request valid
- s_dst_in  in  SRC_N*DST_N  per-source destination mask; source i occupies bits [i*DST_N +: DST_N]
- s_data_in  in  SRC_N*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W]
- s_ready_out  out  SRC_N  source pop; one-hot or zero
- m_valid_out  out  DST_N  per-destination valid
- m_data_out  out  DATA_W  payload of the granted source
- m_ready_in  in  DST_N  per-destination ready
- m_src_id_out  out  max(1,$clog2(SRC_N))  index of the granted source

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Registers and reset values:
  - ptr (last-served index), reset SRC_N-1, so source 0 wins first after reset.
  - locked, reset 0.
  - gnt_r, reset 0.
  - done[DST_N], reset 0.
- Outputs are combinational from registers and inputs. With all s_valid_in=0: m_valid_out=0, s_ready_out=0, m_data_out=0, m_src_id_out=0.
- Unlocked cycle (locked=0):
  - gnt = first i with s_valid_in[i]=1, searching ptr+1, ptr+2, ... modulo SRC_N.
  - If no source is valid, nothing is granted and ptr holds.
- Locked cycle (locked=1): gnt = gnt_r. No re-arbitration; a newly valid higher-priority source waits.
- Master-side signals:
  - m_data_out = s_data_in[gnt].
  - m_src_id_out = gnt.
  - m_valid_out = s_dst_in[gnt] & ~done, gated by s_valid_in[gnt].
- acc = m_valid_out & m_ready_in.
- Completion: (done | acc) == s_dst_in[gnt]. In that cycle:
  - s_ready_out[gnt]=1.
  - ptr <= gnt, done <= 0, locked <= 0.
  - Zero-latency pass-through: the next cycle can grant a new source.
- Partial delivery (acc adds bits, but the mask is not yet complete): done <= done|acc, locked <= 1, gnt_r <= gnt.
- No acceptance: state holds. In an unlocked cycle the choice may change the next cycle, because nothing has been delivered yet.
- Source protocol: once s_valid_in[i]=1, it holds s_valid_in[i], s_dst_in[i] and s_data_in[i] stable until s_ready_out[i]. A violation is a protocol error and its behaviour is undefined.
- dst mask 0 on a granted source: completes in the same cycle with m_valid_out=0 (beat dropped). ptr advances.
- Already-done destinations never see a second valid for the same beat.
- Throughput: 1 beat/cycle when all masked destinations are ready. A beat to 2 destinations that accept in different cycles takes (last accept cycle - first cycle + 1) cycles.
- Reset mid-transfer: done, locked and ptr clear asynchronously. A partially delivered beat is re-sent to all of its destinations after reset if the source still presents it.

Optional Feature:
- Macro: MDA_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is not implemented; m_src_id_out is always the lowest valid index when unlocked. Lock and done tracking are unchanged.
- Undefined: round-robin exactly as in Behaviour.

Decomposition:
- Shared package holds:
  - MDA_SRC_N_MAX=16.
  - A SRC_ID_W function returning max(1,$clog2(SRC_N)).
  - The one-hot-to-index helper function.
- One natural sub-module: rr_pick, a combinational rotate-priority-rotate picker.
  - Inputs: req[SRC_N], ptr.
  - Outputs: gnt_oh, gnt_idx, any.
  - Reused by other arbiters in the codebase.

Test Plan:
- Reset, then src0 and src2 valid, dst=2'b11, both readies 1 → cycle 0: src0 granted, s_ready_out=4'b0001. Cycle 1: src2 granted, s_ready_out=4'b0100. m_data_out matches each source.
- src1 valid, dst=2'b11; m_ready_in=2'b01 in cycle 0, then 2'b10 in cycle 1 → cycle 0: m_valid_out=2'b11. Cycle 1: m_valid_out=2'b10, s_ready_out[1]=1 only in cycle 1. Dest0 sees exactly one handshake.
- Locked on src1 (as above) while src0 asserts valid in cycle 1 → m_src_id_out stays 1 until completion; src0 is granted in the next cycle.
- All 4 sources continuously valid, dst=2'b01, ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3 (with MDA_FIXED_PRIO_EN: 0 every cycle).
- src3 valid with dst=2'b00 → s_ready_out=4'b1000 in the same cycle, m_valid_out=0, ptr=3.
- Assert rst_n=0 mid-partial (done=2'b01) → after release done=0, locked=0. The held beat reappears with m_valid_out=2'b11 and ptr restarts so source 0 has priority.

Source files
------------

// File: rtl/multi_dest_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_dest_rr_arb_pkg
// Purpose  : Shared constants and helpers for the multi-destination arbiter
//            and its round-robin picker.
// Contents : MDA_SRC_N_MAX  - largest supported requester count
//            SRC_ID_W()     - width of a source index, never less than 1
//            onehot_to_idx()- one-hot vector to binary index
// Options  : none (MDA_FIXED_PRIO_EN is consumed by multi_dest_rr_arb)
// Revision : 1.0 - initial release
// ============================================================================
package multi_dest_rr_arb_pkg;

    localparam int MDA_SRC_N_MAX = 16;
    localparam int MDA_IDX_W     = $clog2(MDA_SRC_N_MAX);

    function automatic int SRC_ID_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // OR-reduction encoder: exact for one-hot input, zero for an all-zero input.
    function automatic logic [MDA_IDX_W-1:0] onehot_to_idx(
        input logic [MDA_SRC_N_MAX-1:0] oh
    );
        logic [MDA_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MDA_SRC_N_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | MDA_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_dest_rr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_dest_rr_arb_if
// Purpose  : Handshake bundle between SRC_N requesters, the arbiter and a
//            DST_N-way destination stage.
// Signals  : s_valid_in   [SRC_N]        per-source request valid
//            s_dst_in     [SRC_N*DST_N]  per-source destination mask
//            s_data_in    [SRC_N*DATA_W] per-source payload
//            s_ready_out  [SRC_N]        source pop, one-hot or zero
//            m_valid_out  [DST_N]        per-destination valid
//            m_data_out   [DATA_W]       granted payload
//            m_ready_in   [DST_N]        per-destination ready
//            m_src_id_out [ID_W]         granted source index
// Modports : slave  - the arbiter
//            master - the surrounding requesters and destinations
// Revision : 1.0 - initial release
// ============================================================================
interface multi_dest_rr_arb_if
    import multi_dest_rr_arb_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int SRC_N  = 4,
    parameter int DST_N  = 2
);
    localparam int ID_W = SRC_ID_W(SRC_N);

    logic [SRC_N-1:0]        s_valid_in;
    logic [SRC_N*DST_N-1:0]  s_dst_in;
    logic [SRC_N*DATA_W-1:0] s_data_in;
    logic [SRC_N-1:0]        s_ready_out;
    logic [DST_N-1:0]        m_valid_out;
    logic [DATA_W-1:0]       m_data_out;
    logic [DST_N-1:0]        m_ready_in;
    logic [ID_W-1:0]         m_src_id_out;

    modport slave (
        input  s_valid_in, s_dst_in, s_data_in, m_ready_in,
        output s_ready_out, m_valid_out, m_data_out, m_src_id_out
    );

    modport master (
        output s_valid_in, s_dst_in, s_data_in, m_ready_in,
        input  s_ready_out, m_valid_out, m_data_out, m_src_id_out
    );

endinterface
`default_nettype wire

// File: rtl/multi_dest_rr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : multi_dest_rr_arb_rr_pick
// Purpose  : Combinational rotate / priority / rotate-back picker. Searches
//            req starting at ptr+1 (mod SRC_N) and returns the first hit.
// Ports    : req     in  [SRC_N] request vector
//            ptr     in  [ID_W]  last-served index
//            gnt_oh  out [SRC_N] one-hot grant, zero when no request
//            gnt_idx out [ID_W]  binary grant, zero when no request
//            any     out         at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module multi_dest_rr_arb_rr_pick
    import multi_dest_rr_arb_pkg::*;
#(
    parameter int SRC_N = 4,
    parameter int ID_W  = SRC_ID_W(SRC_N)
) (
    input  logic [SRC_N-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [SRC_N-1:0] gnt_oh,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    localparam logic [ID_W-1:0] c_last = ID_W'(SRC_N - 1);

    logic [ID_W-1:0]  w_start;
    logic [SRC_N-1:0] w_rot;
    logic [SRC_N-1:0] w_rot_oh;

    always_comb begin
        w_start  = (ptr >= c_last) ? '0 : ptr + 1'b1;
        // Rotating a doubled copy right by w_start puts the search start at bit 0.
        w_rot    = SRC_N'({req, req} >> w_start);
        // Isolate the lowest set bit.
        w_rot_oh = w_rot & (~w_rot + 1'b1);
        // Rotate back: the upper half of the doubled copy shifted left.
        gnt_oh   = SRC_N'(({w_rot_oh, w_rot_oh} << w_start) >> SRC_N);
        gnt_idx  = ID_W'(onehot_to_idx(MDA_SRC_N_MAX'(gnt_oh)));
        any      = |req;
    end

endmodule
`default_nettype wire

// File: rtl/multi_dest_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : multi_dest_rr_arb
// Purpose  : Round-robin arbiter sharing one multi-destination broadcast path
//            among SRC_N requesters. Tracks per-destination acceptance and
//            pops a source only once every destination in its mask has taken
//            the beat; a partially delivered beat locks the grant.
// Ports    : clk    in  clock
//            rst_n  in  asynchronous active-low reset
//            bus    slave modport of multi_dest_rr_arb_if (source side
//                   s_valid_in/s_dst_in/s_data_in/s_ready_out, destination
//                   side m_valid_out/m_data_out/m_ready_in/m_src_id_out)
// Options  : MDA_FIXED_PRIO_EN - fixed priority (lowest index wins), no
//            round-robin pointer register. Default: round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module multi_dest_rr_arb
    import multi_dest_rr_arb_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int SRC_N  = 4,
    parameter int DST_N  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_dest_rr_arb_if.slave  bus
);

    localparam int              ID_W      = SRC_ID_W(SRC_N);
    localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(SRC_N - 1);

    logic             r_locked;
    logic [ID_W-1:0]  r_gnt;
    logic [DST_N-1:0] r_done;
    logic [ID_W-1:0]  w_ptr;

`ifdef MDA_FIXED_PRIO_EN
    // A constant "last served = SRC_N-1" makes the picker search from 0.
    assign w_ptr = c_ptr_rst;
`else
    logic [ID_W-1:0]  r_ptr;
    assign w_ptr = r_ptr;
`endif

    logic [SRC_N-1:0]  w_pick_oh;
    logic [ID_W-1:0]   w_pick_idx;
    logic              w_pick_any;
    logic [ID_W-1:0]   w_gnt;
    logic [SRC_N-1:0]  w_gnt_oh;
    logic              w_gnt_vld;
    logic [DST_N-1:0]  w_dst;
    logic [DATA_W-1:0] w_data;
    logic [DST_N-1:0]  w_mvalid;
    logic [DST_N-1:0]  w_acc;
    logic              w_complete;

    multi_dest_rr_arb_rr_pick #(
        .SRC_N (SRC_N),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (bus.s_valid_in),
        .ptr     (w_ptr),
        .gnt_oh  (w_pick_oh),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    always_comb begin
        w_gnt     = r_locked ? r_gnt : w_pick_idx;
        w_gnt_oh  = '0;
        w_gnt_vld = 1'b0;
        w_dst     = '0;
        w_data    = '0;
        for (int i = 0; i < SRC_N; i++) begin
            if (w_gnt == ID_W'(i)) begin
                w_gnt_vld = bus.s_valid_in[i];
                w_dst     = bus.s_dst_in[i*DST_N +: DST_N];
                w_data    = bus.s_data_in[i*DATA_W +: DATA_W];
            end
            if (r_locked && (r_gnt == ID_W'(i))) begin
                w_gnt_oh[i] = 1'b1;
            end
        end
        if (!r_locked) begin
            w_gnt_oh = w_pick_oh;
        end
        // Destinations that already took this beat are masked off.
        w_mvalid   = w_gnt_vld ? (w_dst & ~r_done) : '0;
        w_acc      = w_mvalid & bus.m_ready_in;
        // An all-zero mask satisfies this immediately and drops the beat.
        w_complete = w_gnt_vld && (w_pick_any || r_locked)
                     && ((r_done | w_acc) == w_dst);
    end

    assign bus.m_valid_out  = w_mvalid;
    assign bus.m_data_out   = w_gnt_vld ? w_data : '0;
    assign bus.m_src_id_out = w_gnt;
    assign bus.s_ready_out  = w_complete ? w_gnt_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
            r_gnt    <= '0;
            r_done   <= '0;
`ifndef MDA_FIXED_PRIO_EN
            r_ptr    <= c_ptr_rst;
`endif
        end else if (w_complete) begin
            r_locked <= 1'b0;
            r_done   <= '0;
`ifndef MDA_FIXED_PRIO_EN
            r_ptr    <= w_gnt;
`endif
        end else if (|w_acc) begin
            // Partial delivery: hold this source until the mask is complete.
            r_locked <= 1'b1;
            r_gnt    <= w_gnt;
            r_done   <= r_done | w_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_dest_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_dest_rr_arb
// Purpose  : Self-checking bench for multi_dest_rr_arb (SRC_N=4, DST_N=2).
//            Table of per-cycle vectors with expected outputs, queued as a
//            scoreboard when driven and compared when sampled, plus a
//            hand-written asynchronous-reset-during-partial sequence.
// Options  : honours MDA_FIXED_PRIO_EN for the grant-order expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_dest_rr_arb;

    localparam int DATA_W = 256;
    localparam int SRC_N  = 4;
    localparam int DST_N  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multi_dest_rr_arb_if #(.DATA_W(DATA_W), .SRC_N(SRC_N), .DST_N(DST_N)) bus ();

    multi_dest_rr_arb #(.DATA_W(DATA_W), .SRC_N(SRC_N), .DST_N(DST_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit        rst;
        logic [3:0] v;
        logic [7:0] dst;
        logic [1:0] rdy;
        logic [3:0] sr;
        logic [1:0] mv;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[$];
    vec_t tbl_tail[$];
    vec_t sb[$];
    logic [DATA_W-1:0] src_data [SRC_N];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit tail, input bit r, input logic [3:0] v,
                       input logic [7:0] d, input logic [1:0] rdy,
                       input logic [3:0] sr, input logic [1:0] mv,
                       input logic [1:0] id);
        vec_t t;
        t.rst = r; t.v = v; t.dst = d; t.rdy = rdy;
        t.sr = sr; t.mv = mv; t.id = id;
        if (tail) tbl_tail.push_back(t);
        else      tbl.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid_in = '0;
        bus.s_dst_in   = '0;
        bus.m_ready_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called just after a rising edge; leaves time just after the next one.
    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        logic [DATA_W-1:0] exp_d;
        if (t.rst) do_reset();
        bus.s_valid_in = t.v;
        bus.s_dst_in   = t.dst;
        bus.m_ready_in = t.rdy;
        sb.push_back(t);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            exp_d = e.v[e.id] ? src_data[e.id] : '0;
            chk({tag, " s_ready_out"},  DATA_W'(bus.s_ready_out),  DATA_W'(e.sr));
            chk({tag, " m_valid_out"},  DATA_W'(bus.m_valid_out),  DATA_W'(e.mv));
            chk({tag, " m_src_id_out"}, DATA_W'(bus.m_src_id_out), DATA_W'(e.id));
            chk({tag, " m_data_out"},   bus.m_data_out,            exp_d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rr_id;
        for (int s = 0; s < SRC_N; s++)
            for (int w = 0; w < DATA_W / 32; w++)
                src_data[s][w*32 +: 32] = $urandom;
        bus.s_data_in  = {src_data[3], src_data[2], src_data[1], src_data[0]};
        bus.s_valid_in = '0;
        bus.s_dst_in   = '0;
        bus.m_ready_in = '0;

        //      tail rst  valid    dst    rdy    s_ready  m_valid id
        add(0, 1, 4'b0000, 8'h00, 2'b00, 4'b0000, 2'b00, 2'd0); // reset state
        add(0, 0, 4'b0101, 8'hFF, 2'b11, 4'b0001, 2'b11, 2'd0); // src0 first
        add(0, 0, 4'b0100, 8'hFF, 2'b11, 4'b0100, 2'b11, 2'd2); // then src2
        add(0, 0, 4'b0010, 8'hFF, 2'b01, 4'b0000, 2'b11, 2'd1); // partial: dst0
        add(0, 0, 4'b0011, 8'hFF, 2'b00, 4'b0000, 2'b10, 2'd1); // locked, src0 waits
        add(0, 0, 4'b0011, 8'hFF, 2'b10, 4'b0010, 2'b10, 2'd1); // dst1 completes
        add(0, 0, 4'b0001, 8'hFF, 2'b11, 4'b0001, 2'b11, 2'd0); // src0 next
        add(0, 0, 4'b1000, 8'h00, 2'b11, 4'b1000, 2'b00, 2'd3); // empty mask drops
        add(0, 0, 4'b1111, 8'h55, 2'b11, 4'b0001, 2'b01, 2'd0); // ptr moved to 3
        add(0, 0, 4'b0110, 8'h55, 2'b00, 4'b0000, 2'b01, 2'd1); // no acceptance
        add(0, 0, 4'b0110, 8'h55, 2'b01, 4'b0010, 2'b01, 2'd1);
        for (int k = 0; k < 8; k++) begin
`ifdef MDA_FIXED_PRIO_EN
            rr_id = 2'd0;
`else
            rr_id = 2'(k % 4);
`endif
            add(0, k == 0, 4'b1111, 8'h55, 2'b01, 4'b0001 << rr_id, 2'b01, rr_id);
        end
        add(0, 0, 4'b0100, 8'h55, 2'b01, 4'b0100, 2'b01, 2'd2); // last served = 2
        add(0, 0, 4'b0100, 8'hFF, 2'b01, 4'b0000, 2'b11, 2'd2); // partial, done=01
        // After the mid-partial reset: ptr back to 3 so {2,3} resolves to 2.
        add(1, 0, 4'b1100, 8'hFF, 2'b00, 4'b0000, 2'b11, 2'd2);
        add(1, 0, 4'b1100, 8'hFF, 2'b11, 4'b0100, 2'b11, 2'd2);
        add(1, 0, 4'b1000, 8'hFF, 2'b11, 4'b1000, 2'b11, 2'd3);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("row%0d", i));

        // Locked on src2 with dst0 delivered; reset asynchronously mid-cycle.
        bus.s_valid_in = 4'b0100;
        bus.s_dst_in   = 8'hFF;
        bus.m_ready_in = 2'b00;
        #1;
        chk("pre-reset m_valid_out", DATA_W'(bus.m_valid_out), DATA_W'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("async reset m_valid_out",  DATA_W'(bus.m_valid_out),  DATA_W'(2'b11));
        chk("async reset m_src_id_out", DATA_W'(bus.m_src_id_out), DATA_W'(2'd2));
        chk("async reset s_ready_out",  DATA_W'(bus.s_ready_out),  DATA_W'(4'b0000));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl_tail.size(); i++)
            apply(tbl_tail[i], $sformatf("tail%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
